// File: rtl/sha_pkg.sv
// Shared constants for the nonce dispatcher: FSM state codes, result status codes
// and the fixed SHA-256 padding words of the 80-byte block header's second chunk.
package sha_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;

    localparam logic [1:0] STATUS_HIT       = 2'd0;
    localparam logic [1:0] STATUS_EXHAUSTED = 2'd1;
    localparam logic [1:0] STATUS_ABORTED   = 2'd2;

    localparam logic [31:0] SHA_PAD_WORD4 = 32'h80000000;
    localparam logic [31:0] SHA_LEN_WORD  = 32'h00000280;

    // Second 64-byte chunk of an 80-byte header: 12 tail bytes, nonce, 0x80 pad, bit length 640.
    function automatic logic [511:0] build_head(input logic [95:0] tail, input logic [31:0] nonce);
        return {SHA_LEN_WORD, 320'd0, SHA_PAD_WORD4, nonce, tail};
    endfunction

endpackage

// File: rtl/header_builder.sv
// Combinational assembly of the padded 512-bit headData block from the header tail and nonce.
module header_builder
    import sha_pkg::*;
(
    input  logic [95:0]  tail,
    input  logic [31:0]  nonce,
    output logic [511:0] head_data
);

    assign head_data = build_head(tail, nonce);

endmodule

// File: rtl/nonce_dispatcher.sv
// Work-side driver for one sha_core/cycleCounter pair: steps the nonce once per 64-cycle
// pass, watches for hits and reports HIT / EXHAUSTED / ABORTED over a valid/ready port.
module nonce_dispatcher
    import sha_pkg::*;
#(
    parameter int DRAIN_CYCLES = 128,
    parameter bit STOP_ON_HIT  = 1'b0
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_midState,
    input  logic [95:0]  work_tail,
    input  logic [31:0]  work_nonceLo,
    input  logic [31:0]  work_nonceHi,
    input  logic         abort,
    output logic [255:0] midState,
    output logic [511:0] headData,
    output logic [31:0]  nonce,
    output logic         solveEn,
    output logic         clearCounter,
    input  logic [5:0]   cycle,
    input  logic [32:0]  coreOutput,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [31:0]  res_nonce,
    output logic [1:0]   res_status
);

    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  resume_state;
    logic [95:0] tail_q;
    logic [31:0] nonce_hi;
    logic [15:0] drain_cnt;
    logic        abort_pending;

    logic hit;
    logic pass_end;
    logic last_nonce;
    logic drain_done;
    logic [2:0] run_next;

    header_builder u_header_builder (
        .tail      (tail_q),
        .nonce     (nonce),
        .head_data (headData)
    );

    // A deferred abort (lost to a simultaneous hit) holds the counter until it is reported.
    assign work_ready   = (state == ST_IDLE);
    assign res_valid    = (state == ST_REPORT);
    assign clearCounter = (state != ST_LOAD);
    assign solveEn      = ((state == ST_RUN) || (state == ST_DRAIN)) && !abort_pending;

    assign hit        = coreOutput[32];
    assign pass_end   = solveEn && (cycle == 6'd63);
    assign last_nonce = (nonce == nonce_hi);
    assign drain_done = solveEn && (drain_cnt == DRAIN_LAST);
    assign run_next   = (pass_end && last_nonce) ? ST_DRAIN : ST_RUN;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= ST_IDLE;
            resume_state  <= ST_IDLE;
            midState      <= '0;
            tail_q        <= '0;
            nonce         <= '0;
            nonce_hi      <= '0;
            drain_cnt     <= '0;
            abort_pending <= 1'b0;
            res_nonce     <= '0;
            res_status    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (work_valid) begin
                        midState      <= work_midState;
                        tail_q        <= work_tail;
                        nonce         <= work_nonceLo;
                        nonce_hi      <= work_nonceHi;
                        abort_pending <= 1'b0;
                        state         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        res_status   <= STATUS_ABORTED;
                        res_nonce    <= '0;
                        resume_state <= ST_IDLE;
                        state        <= ST_REPORT;
                    end else if (nonce > nonce_hi) begin
                        res_status   <= STATUS_EXHAUSTED;
                        res_nonce    <= '0;
                        resume_state <= ST_IDLE;
                        state        <= ST_REPORT;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The counter still wraps on a hit edge, so the nonce step happens regardless.
                    if (pass_end && !last_nonce) begin
                        nonce <= nonce + 32'd1;
                    end
                    if (pass_end && last_nonce) begin
                        drain_cnt <= '0;
                    end
                    if (hit) begin
                        res_status   <= STATUS_HIT;
                        res_nonce    <= coreOutput[31:0];
                        resume_state <= run_next;
                        state        <= ST_REPORT;
                        if (abort) begin
                            abort_pending <= 1'b1;
                        end
                    end else if (abort || abort_pending) begin
                        res_status    <= STATUS_ABORTED;
                        res_nonce     <= '0;
                        resume_state  <= ST_IDLE;
                        abort_pending <= 1'b0;
                        state         <= ST_REPORT;
                    end else begin
                        state <= run_next;
                    end
                end
                ST_DRAIN: begin
                    if (solveEn) begin
                        drain_cnt <= drain_cnt + 16'd1;
                    end
                    if (hit) begin
                        res_status   <= STATUS_HIT;
                        res_nonce    <= coreOutput[31:0];
                        resume_state <= drain_done ? ST_IDLE : ST_DRAIN;
                        state        <= ST_REPORT;
                        if (abort) begin
                            abort_pending <= 1'b1;
                        end
                    end else if (abort || abort_pending) begin
                        res_status    <= STATUS_ABORTED;
                        res_nonce     <= '0;
                        resume_state  <= ST_IDLE;
                        abort_pending <= 1'b0;
                        state         <= ST_REPORT;
                    end else if (drain_done) begin
                        res_status   <= STATUS_EXHAUSTED;
                        res_nonce    <= '0;
                        resume_state <= ST_IDLE;
                        state        <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        if (STOP_ON_HIT || (resume_state == ST_IDLE)) begin
                            abort_pending <= 1'b0;
                            state         <= ST_IDLE;
                        end else begin
                            state <= resume_state;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed self-checking bench for nonce_dispatcher with a behavioural cycleCounter
// and a hand-driven coreOutput standing in for sha_core.
module tb_nonce_dispatcher;

    localparam int DRAIN = 128;

    logic         clk;
    logic         n_rst;
    logic         work_valid;
    logic         work_ready;
    logic [255:0] work_midState;
    logic [95:0]  work_tail;
    logic [31:0]  work_nonceLo;
    logic [31:0]  work_nonceHi;
    logic         abort;
    logic [255:0] midState;
    logic [511:0] headData;
    logic [31:0]  nonce;
    logic         solveEn;
    logic         clearCounter;
    logic [5:0]   cycle;
    logic [32:0]  coreOutput;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_nonce;
    logic [1:0]   res_status;

    int testCount = 0;
    int failCount = 0;

    nonce_dispatcher #(.DRAIN_CYCLES(DRAIN), .STOP_ON_HIT(1'b0)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .work_valid    (work_valid),
        .work_ready    (work_ready),
        .work_midState (work_midState),
        .work_tail     (work_tail),
        .work_nonceLo  (work_nonceLo),
        .work_nonceHi  (work_nonceHi),
        .abort         (abort),
        .midState      (midState),
        .headData      (headData),
        .nonce         (nonce),
        .solveEn       (solveEn),
        .clearCounter  (clearCounter),
        .cycle         (cycle),
        .coreOutput    (coreOutput),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_nonce     (res_nonce),
        .res_status    (res_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for cycleCounter: active-low clear, counts while solveEn is high.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) cycle <= '0;
        else if (!clearCounter) cycle <= '0;
        else if (solveEn) cycle <= cycle + 6'd1;
    end

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [255:0] mid, input logic [95:0] tail,
                                 input logic [31:0] lo, input logic [31:0] hi);
        bit accepted = 1'b0;
        work_midState = mid;
        work_tail     = tail;
        work_nonceLo  = lo;
        work_nonceHi  = hi;
        work_valid    = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = work_ready;
            step();
        end
        work_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic waitResult(input int limit, output int cycles);
        cycles = 0;
        while (!res_valid && cycles < limit) begin
            step();
            cycles++;
        end
        if (!res_valid) checkOutput("result_timeout", 0, 1);
    endtask

    task automatic waitCycleRun(input logic [5:0] target);
        int n = 0;
        while (!(solveEn && cycle == target) && n < 300) begin
            step();
            n++;
        end
        if (!(solveEn && cycle == target)) checkOutput("cycle_timeout", 0, 1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        logic [255:0] mid2;
        logic [95:0]  tail2;
        int cycles;

        mid2  = 256'h283048996015d72e_c7d1b3a4_9e0f2a51_6b8c4d37_e2a9f01c_5d7b3e86_1e397ddc;
        tail2 = {32'h61481b18, 32'h76167e54, 32'h7dab00c4};
        n_rst = 1'b0; work_valid = 1'b0; work_midState = '0; work_tail = '0;
        work_nonceLo = '0; work_nonceHi = '0; abort = 1'b0; coreOutput = '0; res_ready = 1'b0;

        #1;
        checkOutput("rst_work_ready", work_ready, 1);
        checkOutput("rst_solveEn", solveEn, 0);
        checkOutput("rst_clearCounter", clearCounter, 1);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_nonce", nonce, 0);
        checkOutput("rst_res_nonce", res_nonce, 0);
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        step();

        // Single-nonce hit, then the pass finishes and the range exhausts.
        applyStimulus(mid2, tail2, 32'd411342221, 32'd411342221);
        checkOutput("t2_load_clear", clearCounter, 0);
        checkOutput("t2_load_solve", solveEn, 0);
        waitCycleRun(6'd20);
        checkOutput("t2_midState", midState, mid2);
        checkOutput("t2_head_nonce", headData[127:96], 32'h1884958D);
        checkOutput("t2_head_tail", headData[95:0], tail2);
        checkOutput("t2_head_pad", headData[159:128], 32'h80000000);
        checkOutput("t2_head_zero", headData[479:160], 0);
        checkOutput("t2_head_len", headData[511:480], 32'h00000280);
        coreOutput = {1'b1, 32'd411342221};
        step();
        coreOutput = '0;
        checkOutput("t2_hit_valid", res_valid, 1);
        checkOutput("t2_hit_status", res_status, 0);
        checkOutput("t2_hit_nonce", res_nonce, 32'd411342221);
        checkOutput("t2_hit_paused", solveEn, 0);
        handshake();
        checkOutput("t2_resume_valid", res_valid, 0);
        checkOutput("t2_resume_solve", solveEn, 1);
        waitResult(1000, cycles);
        checkOutput("t2_exh_status", res_status, 1);
        handshake();

        // Range 5..7 without hits: nonce steps on each 63->0 edge.
        applyStimulus('0, 96'h1, 32'd5, 32'd7);
        cycles = 0;
        for (int i = 1; i <= 600 && !res_valid; i++) begin
            step();
            cycles = i;
            if (i == 64)  checkOutput("t3_nonce_a", nonce, 5);
            if (i == 65)  checkOutput("t3_nonce_b", nonce, 6);
            if (i == 129) checkOutput("t3_nonce_c", nonce, 7);
            if (i == 193) checkOutput("t3_drain_solve", solveEn, 1);
            if (i == 194) checkOutput("t3_drain_nonce", nonce, 7);
        end
        checkOutput("t3_valid", res_valid, 1);
        checkOutput("t3_latency", cycles, 3 * 64 + DRAIN + 1);
        checkOutput("t3_status", res_status, 1);
        checkOutput("t3_res_nonce", res_nonce, 0);
        handshake();
        checkOutput("t3_idle", work_ready, 1);

        // Back-pressure on a hit at the end of a pass; resumes on the next nonce.
        applyStimulus('0, 96'h2, 32'd100, 32'd102);
        waitCycleRun(6'd63);
        coreOutput = {1'b1, 32'd100};
        step();
        coreOutput = '0;
        for (int i = 0; i < 10; i++) begin
            checkOutput("t4_hold_valid", res_valid, 1);
            checkOutput("t4_hold_nonce", res_nonce, 100);
            checkOutput("t4_hold_solve", solveEn, 0);
            step();
        end
        handshake();
        checkOutput("t4_release_valid", res_valid, 0);
        checkOutput("t4_release_solve", solveEn, 1);
        checkOutput("t4_next_nonce", nonce, 101);
        waitResult(1000, cycles);
        checkOutput("t4_exh_status", res_status, 1);
        checkOutput("t4_exh_nonce", nonce, 102);
        handshake();

        // Top of the nonce space: one pass, no wrap.
        applyStimulus('0, 96'h3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitResult(1000, cycles);
        checkOutput("t5_max_latency", cycles, 64 + DRAIN + 1);
        checkOutput("t5_max_status", res_status, 1);
        checkOutput("t5_max_nonce", nonce, 32'hFFFFFFFF);
        handshake();

        // Empty range: LOAD then straight to the report.
        applyStimulus('0, 96'h4, 32'd9, 32'd3);
        checkOutput("t5_empty_solve", solveEn, 0);
        step();
        checkOutput("t5_empty_valid", res_valid, 1);
        checkOutput("t5_empty_status", res_status, 1);
        checkOutput("t5_empty_solve2", solveEn, 0);
        handshake();

        // Abort during RUN.
        applyStimulus('0, 96'h5, 32'd0, 32'd10);
        waitCycleRun(6'd5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("t6_abort_solve", solveEn, 0);
        checkOutput("t6_abort_valid", res_valid, 1);
        checkOutput("t6_abort_status", res_status, 2);
        checkOutput("t6_abort_nonce", res_nonce, 0);
        handshake();
        checkOutput("t6_abort_idle", work_ready, 1);

        // Hit and abort together: HIT first, ABORTED after the handshake.
        applyStimulus('0, 96'h6, 32'd20, 32'd30);
        waitCycleRun(6'd10);
        abort = 1'b1;
        coreOutput = {1'b1, 32'd25};
        step();
        abort = 1'b0;
        coreOutput = '0;
        checkOutput("t6_both_status", res_status, 0);
        checkOutput("t6_both_nonce", res_nonce, 25);
        handshake();
        checkOutput("t6_both_gap_valid", res_valid, 0);
        checkOutput("t6_both_gap_solve", solveEn, 0);
        step();
        checkOutput("t6_both_abort_valid", res_valid, 1);
        checkOutput("t6_both_abort_status", res_status, 2);
        checkOutput("t6_both_abort_nonce", res_nonce, 0);
        handshake();
        checkOutput("t6_both_idle", work_ready, 1);

        // Asynchronous reset in the middle of a RUN.
        applyStimulus('1, 96'h7, 32'd0, 32'd100);
        repeat (30) step();
        checkOutput("t1_pre_solve", solveEn, 1);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("t1_solve", solveEn, 0);
        checkOutput("t1_res_valid", res_valid, 0);
        checkOutput("t1_work_ready", work_ready, 1);
        checkOutput("t1_midState", midState, 0);
        checkOutput("t1_nonce", nonce, 0);
        step();
        n_rst = 1'b1;
        repeat (3) step();
        checkOutput("t1_after_valid", res_valid, 0);
        checkOutput("t1_after_ready", work_ready, 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
